// File: rtl/encoder_4_2_seq_amisha_pkg.sv
// Shared definitions for the sequential priority encoder.
//  - N_IN_DEF   : default number of request lines.
//  - ST_IDLE    : FSM state with nothing presented (valid_amisha = 0).
//  - ST_PRESENT : FSM state with an index on a_amisha (valid_amisha = 1).
package encoder_4_2_seq_amisha_pkg;

  localparam int N_IN_DEF = 4;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

endpackage

// File: rtl/prio_enc_comb_amisha.sv
// Purely combinational priority encoder, highest index wins.
// Ports:
//  in_vec [N_IN-1:0]  : request vector
//  idx    [W_OUT-1:0] : index of the highest set bit (0 when none set)
//  any                : 1 when at least one bit of in_vec is set
module prio_enc_comb_amisha #(
  parameter  int N_IN  = 4,
  localparam int W_OUT = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  in_vec,
  output logic [W_OUT-1:0] idx,
  output logic             any
);

  // Ascending scan: a later (higher) set bit overwrites an earlier one.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (in_vec[i]) begin
        idx = W_OUT'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_4_2_seq_amisha.sv
// Sequential priority encoder. Multi-hot requests are captured into a
// pending register and served one index per handshake, highest index first.
// Ports:
//  clk_amisha    : clock, rising edge
//  rst_n_amisha  : asynchronous active-low reset
//  en_amisha     : 1 = capture req_amisha this cycle
//  req_amisha    : request lines (multi-hot)
//  ready_amisha  : consumer accepts a_amisha this cycle
//  a_amisha      : registered index being presented
//  valid_amisha  : a_amisha is valid (registered, equals FSM state)
//  pend_amisha   : pending-request flags, for debug/status
//  idle_amisha   : FSM idle and nothing pending
//
// Handshake: a transfer happens on a rising edge where valid_amisha and
// ready_amisha are both 1. While valid_amisha=1 and ready_amisha=0, a_amisha
// and valid_amisha hold. ready_amisha is ignored while valid_amisha=0.
module encoder_4_2_seq_amisha
  import encoder_4_2_seq_amisha_pkg::*;
#(
  parameter  int N_IN  = N_IN_DEF,
  localparam int W_OUT = $clog2(N_IN)
) (
  input  logic             clk_amisha,
  input  logic             rst_n_amisha,
  input  logic             en_amisha,
  input  logic [N_IN-1:0]  req_amisha,
  input  logic             ready_amisha,
  output logic [W_OUT-1:0] a_amisha,
  output logic             valid_amisha,
  output logic [N_IN-1:0]  pend_amisha,
  output logic             idle_amisha
);

  logic [0:0]       state;
  logic [N_IN-1:0]  pend;
  logic [N_IN-1:0]  set_vec;
  logic [N_IN-1:0]  clr_vec;
  logic [N_IN-1:0]  pend_next;
  logic [W_OUT-1:0] a_reg;
  logic [W_OUT-1:0] nxt_idx;
  logic             nxt_any;

  assign set_vec = en_amisha ? req_amisha : '0;

  // The presented bit is still held in pend; it is cleared on the transfer.
  assign clr_vec = ((state == ST_PRESENT) && ready_amisha) ? (N_IN'(1) << a_reg) : '0;

  // Set is OR-ed in after the clear so a re-request of the served bit re-arms it.
  assign pend_next = (pend & ~clr_vec) | set_vec;

  // In IDLE clr_vec is zero, so pend_next reduces to pend|set.
  prio_enc_comb_amisha #(.N_IN(N_IN)) u_prio (
    .in_vec (pend_next),
    .idx    (nxt_idx),
    .any    (nxt_any)
  );

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state <= ST_IDLE;
      pend  <= '0;
      a_reg <= '0;
    end else begin
      pend <= pend_next;
      case (state)
        ST_IDLE: begin
          if (nxt_any) begin
            a_reg <= nxt_idx;
            state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // No pre-emption: a_reg only changes on a completed transfer.
          if (ready_amisha) begin
            if (nxt_any) begin
              a_reg <= nxt_idx;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign a_amisha     = a_reg;
  assign valid_amisha = (state == ST_PRESENT);
  assign pend_amisha  = pend;
  assign idle_amisha  = (state == ST_IDLE) && (pend == '0);

endmodule
